// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the unified-memory responder:
// func3 encodings, FSM states, port IDs and the access legality check.
package mem_resp_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Fetches are always word accesses; func3 only matters for the data port.
  function automatic logic access_err(input logic port, input logic we,
                                      input logic [2:0] f3, input logic [1:0] off);
    logic e;
    e = 1'b0;
    if (port == PORT_IF) begin
      e = (off != 2'b00);
    end else if (we) begin
      case (f3)
        F3_B:    e = 1'b0;
        F3_H:    e = off[0];
        F3_W:    e = (off != 2'b00);
        default: e = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: e = 1'b0;
        F3_H, F3_HU: e = off[0];
        F3_W:        e = (off != 2'b00);
        default:     e = 1'b1;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Fetch and data request/response bundle between the core and mem_responder.
interface mem_responder_if #(
  parameter int ADDR_W = 8
);

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              if_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_rdata;
  logic              d_rsp_err;

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_valid, d_we, d_func3, d_addr, d_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_valid, d_we, d_func3, d_addr, d_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );

endinterface

// File: rtl/mem_byte_array.sv
// Four byte-wide banks sharing one word-indexed port; synchronous read,
// per-lane write enables. Contents are never reset.
module mem_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-3:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

  logic [7:0] bank [4][DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) bank[i][idx] <= wdata[8*i +: 8];
        rdata[8*i +: 8] <= bank[i][idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Unified I/D memory responder: arbitrates fetch vs data, one access in
// flight, optional wait states, little-endian sub-word loads/stores.
module mem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  import mem_resp_pkg::*;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  mem_state_t        state, state_nx;
  logic [2:0]        wcnt;
  logic [1:0]        starve;
  logic              if_wins, acc_if, acc_d, accept, commit;

  logic              q_port, q_we;
  logic [2:0]        q_f3;
  logic [ADDR_W-1:0] q_addr;
  logic [31:0]       q_wdata;

  logic              s_port, s_we, s_err;
  logic [2:0]        s_f3;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;

  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       rword;
  logic              r_err;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_val;

  always_comb begin
    if_wins          = bus.if_req_valid && (!bus.d_req_valid || starve == 2'd2);
    bus.if_req_ready = rst && (state == IDLE) && if_wins;
    bus.d_req_ready  = rst && (state == IDLE) && !if_wins;
    acc_if           = bus.if_req_valid && bus.if_req_ready;
    acc_d            = bus.d_req_valid && bus.d_req_ready;
    accept           = acc_if || acc_d;
  end

  // With zero wait states the memory commits on the accept edge itself, so
  // the access fields come straight from the winning request while in IDLE.
  always_comb begin
    s_port  = q_port;
    s_we    = q_we;
    s_f3    = q_f3;
    s_addr  = q_addr;
    s_wdata = q_wdata;
    if (state == IDLE) begin
      s_port  = acc_if ? PORT_IF : PORT_D;
      s_we    = acc_d && bus.d_we;
      s_f3    = acc_if ? F3_W : bus.d_func3;
      s_addr  = acc_if ? bus.if_addr : bus.d_addr;
      s_wdata = bus.d_wdata;
    end
    s_err = access_err(s_port, s_we, s_f3, s_addr[1:0]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (WS == 3'd0) ? RESP : WAIT;
      WAIT: if (wcnt == 3'd0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    commit = (state_nx == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      starve  <= '0;
      q_port  <= PORT_IF;
      q_we    <= 1'b0;
      q_f3    <= '0;
      q_addr  <= '0;
      q_wdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wcnt    <= WS;
        q_port  <= s_port;
        q_we    <= s_we;
        q_f3    <= s_f3;
        q_addr  <= s_addr;
        q_wdata <= s_wdata;
      end else if (state == WAIT && wcnt != 3'd0) begin
        wcnt <= wcnt - 3'd1;
      end
      if (acc_if) starve <= '0;
      else if (acc_d && bus.if_req_valid) starve <= starve + 2'd1;
    end
  end

  // Store data is replicated across lanes; the enables pick the target bytes.
  always_comb begin
    lane_we    = '0;
    lane_wdata = s_wdata;
    case (s_f3)
      F3_B: begin
        lane_we    = 4'b0001 << s_addr[1:0];
        lane_wdata = {4{s_wdata[7:0]}};
      end
      F3_H: begin
        lane_we    = s_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{s_wdata[15:0]}};
      end
      F3_W:    lane_we = 4'b1111;
      default: lane_we = '0;
    endcase
    if (!(commit && s_we && !s_err)) lane_we = '0;
  end

  mem_byte_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .en   (commit),
    .we   (lane_we),
    .idx  (s_addr[ADDR_W-1:2]),
    .wdata(lane_wdata),
    .rdata(rword)
  );

  // Response is built from the latched request and the registered read word,
  // gated by the RESP state so an asynchronous reset drops it immediately.
  always_comb begin
    r_err  = access_err(q_port, q_we, q_f3, q_addr[1:0]);
    ld_b   = rword[{q_addr[1:0], 3'b000} +: 8];
    ld_h   = q_addr[1] ? rword[31:16] : rword[15:0];
    case (q_f3)
      F3_B:    ld_val = {{24{ld_b[7]}}, ld_b};
      F3_BU:   ld_val = {24'd0, ld_b};
      F3_H:    ld_val = {{16{ld_h[15]}}, ld_h};
      F3_HU:   ld_val = {16'd0, ld_h};
      F3_W:    ld_val = rword;
      default: ld_val = '0;
    endcase

    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_data  = '0;
    bus.if_rsp_err   = 1'b0;
    bus.d_rsp_valid  = 1'b0;
    bus.d_rsp_rdata  = '0;
    bus.d_rsp_err    = 1'b0;
    if (state == RESP) begin
      if (q_port == PORT_IF) begin
        bus.if_rsp_valid = 1'b1;
        bus.if_rsp_err   = r_err;
        bus.if_rsp_data  = r_err ? '0 : rword;
      end else begin
        bus.d_rsp_valid = 1'b1;
        bus.d_rsp_err   = r_err;
        bus.d_rsp_rdata = (r_err || q_we) ? '0 : ld_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboarded accesses on a zero-wait
// instance, cycle-exact latency and reset-abort checks on a 3-wait instance.
module tb_mem_responder;

  import mem_resp_pkg::*;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb0[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(8)) bus0 ();
  mem_responder_if #(.ADDR_W(8)) bus3 ();

  mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_responder #(.ADDR_W(8), .WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Scoreboard consumer for the zero-wait instance.
  always @(negedge clk) begin
    if (rst && (bus0.if_rsp_valid || bus0.d_rsp_valid)) begin
      chk("overlap0", 32'(bus0.if_rsp_valid & bus0.d_rsp_valid), 32'd0);
      if (sb0.size() == 0) begin
        chk("unexpected_rsp0", 32'(sb0.size()), 32'd1);
      end else begin
        mon_e = sb0.pop_front();
        if (mon_e.port == PORT_IF) begin
          chk("if_rsp_valid", 32'(bus0.if_rsp_valid), 32'd1);
          chk("if_rsp_data", bus0.if_rsp_data, mon_e.data);
          chk("if_rsp_err", 32'(bus0.if_rsp_err), 32'(mon_e.err));
          chk("d_quiet", bus0.d_rsp_rdata | 32'({bus0.d_rsp_valid, bus0.d_rsp_err}), 32'd0);
        end else begin
          chk("d_rsp_valid", 32'(bus0.d_rsp_valid), 32'd1);
          chk("d_rsp_rdata", bus0.d_rsp_rdata, mon_e.data);
          chk("d_rsp_err", 32'(bus0.d_rsp_err), 32'(mon_e.err));
          chk("if_quiet", bus0.if_rsp_data | 32'({bus0.if_rsp_valid, bus0.if_rsp_err}), 32'd0);
        end
      end
    end
  end

  task automatic drain0(input string tag);
    int k;
    k = 0;
    while (sb0.size() != 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_rsp"}, 32'(sb0.size()), 32'd0);
  endtask

  task automatic acc0(input logic port, input logic we, input logic [2:0] f3,
                      input logic [7:0] addr, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input string tag);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    @(negedge clk);
    if (port == PORT_IF) begin
      bus0.if_req_valid = 1'b1;
      bus0.if_addr      = addr;
    end else begin
      bus0.d_req_valid = 1'b1;
      bus0.d_we        = we;
      bus0.d_func3     = f3;
      bus0.d_addr      = addr;
      bus0.d_wdata     = wd;
    end
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if ((port == PORT_IF) ? bus0.if_req_ready : bus0.d_req_ready) begin
        e.port = port;
        e.data = ed;
        e.err  = ee;
        sb0.push_back(e);
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    #1;
    bus0.if_req_valid = 1'b0;
    bus0.d_req_valid  = 1'b0;
    bus0.if_addr      = addr ^ 8'h04;
    bus0.d_addr       = addr ^ 8'h04;
    bus0.d_func3      = 3'd2;
    bus0.d_wdata      = ~wd;
    drain0(tag);
  endtask

  task automatic req3(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                      input logic [31:0] wd, input string tag);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus3.d_req_valid = 1'b1;
    bus3.d_we        = we;
    bus3.d_func3     = f3;
    bus3.d_addr      = addr;
    bus3.d_wdata     = wd;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (bus3.d_req_ready) begin
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    #1;
    bus3.d_req_valid = 1'b0;
    bus3.d_addr      = ~addr;
    bus3.d_wdata     = ~wd;
  endtask

  // Cycle k is the cycle after edge T+k, where T is the accept edge.
  task automatic timed3(input logic [31:0] ed, input string tag);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("%s_ready_c%0d", tag, k),
          32'(bus3.d_req_ready | bus3.if_req_ready), 32'(k == 5));
      chk($sformatf("%s_valid_c%0d", tag, k), 32'(bus3.d_rsp_valid), 32'(k == 4));
      if (k == 4) begin
        chk({tag, "_data"}, bus3.d_rsp_rdata, ed);
        chk({tag, "_err"}, 32'(bus3.d_rsp_err), 32'd0);
      end
    end
  endtask

  initial begin
    logic [5:0] exp_g;
    logic       gr;
    bit         ok;
    exp_t       e;

    bus0.if_req_valid = 1'b0; bus0.if_addr = '0;
    bus0.d_req_valid = 1'b0; bus0.d_we = 1'b0; bus0.d_func3 = '0;
    bus0.d_addr = '0; bus0.d_wdata = '0;
    bus3.if_req_valid = 1'b0; bus3.if_addr = '0;
    bus3.d_req_valid = 1'b0; bus3.d_we = 1'b0; bus3.d_func3 = '0;
    bus3.d_addr = '0; bus3.d_wdata = '0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out0", bus0.if_rsp_data | bus0.d_rsp_rdata |
        32'({bus0.if_rsp_valid, bus0.if_rsp_err, bus0.d_rsp_valid, bus0.d_rsp_err,
             bus0.if_req_ready, bus0.d_req_ready}), 32'd0);
    chk("rst_out3", bus3.if_rsp_data | bus3.d_rsp_rdata |
        32'({bus3.if_rsp_valid, bus3.if_rsp_err, bus3.d_rsp_valid, bus3.d_rsp_err,
             bus3.if_req_ready, bus3.d_req_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_d_ready", 32'(bus0.d_req_ready), 32'd1);
    chk("post_rst_if_ready", 32'(bus0.if_req_ready), 32'd0);

    acc0(PORT_D, 1'b1, F3_W, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    acc0(PORT_D, 1'b0, F3_W, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
    acc0(PORT_D, 1'b0, F3_B, 8'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb13");
    acc0(PORT_D, 1'b0, F3_BU, 8'h13, 32'h0, 32'h000000DE, 1'b0, "lbu13");
    acc0(PORT_D, 1'b0, F3_H, 8'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh12");
    acc0(PORT_D, 1'b0, F3_HU, 8'h12, 32'h0, 32'h0000DEAD, 1'b0, "lhu12");
    acc0(PORT_D, 1'b1, F3_B, 8'h11, 32'hAAAAAA55, 32'h0, 1'b0, "sb11");
    acc0(PORT_D, 1'b0, F3_W, 8'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw10_sb");
    acc0(PORT_D, 1'b1, F3_W, 8'h14, 32'h12345678, 32'h0, 1'b0, "sw14");
    acc0(PORT_D, 1'b1, F3_H, 8'h16, 32'h7777BEEF, 32'h0, 1'b0, "sh16");
    acc0(PORT_D, 1'b0, F3_W, 8'h14, 32'h0, 32'hBEEF5678, 1'b0, "lw14");
    acc0(PORT_D, 1'b0, F3_B, 8'h14, 32'h0, 32'h00000078, 1'b0, "lb14");

    acc0(PORT_D, 1'b0, F3_H, 8'h11, 32'h0, 32'h0, 1'b1, "err_lh11");
    acc0(PORT_D, 1'b0, F3_W, 8'h12, 32'h0, 32'h0, 1'b1, "err_lw12");
    acc0(PORT_IF, 1'b0, F3_W, 8'h06, 32'h0, 32'h0, 1'b1, "err_fetch06");
    acc0(PORT_D, 1'b0, 3'd3, 8'h10, 32'h0, 32'h0, 1'b1, "err_ld_f3_3");
    acc0(PORT_D, 1'b1, F3_W, 8'h12, 32'hFFFFFFFF, 32'h0, 1'b1, "err_sw12");
    acc0(PORT_D, 1'b1, 3'd4, 8'h10, 32'hFFFFFFFF, 32'h0, 1'b1, "err_st_f3_4");
    acc0(PORT_D, 1'b0, F3_W, 8'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw10_after_err");
    acc0(PORT_IF, 1'b0, F3_W, 8'h10, 32'h0, 32'hDEAD55EF, 1'b0, "fetch10");

    // Both requesters held valid: expect D, D, IF, D, D, IF.
    exp_g = 6'b100100;
    @(negedge clk);
    bus0.d_req_valid  = 1'b1;
    bus0.d_we         = 1'b0;
    bus0.d_func3      = F3_W;
    bus0.d_addr       = 8'h10;
    bus0.if_req_valid = 1'b1;
    bus0.if_addr      = 8'h14;
    for (int g = 0; g < 6; g++) begin
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
        #1;
        if (bus0.if_req_ready || bus0.d_req_ready) begin
          gr = bus0.if_req_ready;
          chk("arb_onehot", 32'(bus0.if_req_ready & bus0.d_req_ready), 32'd0);
          chk($sformatf("arb_grant%0d", g), 32'(gr), 32'(exp_g[g]));
          e.port = gr ? PORT_IF : PORT_D;
          e.data = gr ? 32'hBEEF5678 : 32'hDEAD55EF;
          e.err  = 1'b0;
          sb0.push_back(e);
          ok = 1'b1;
          @(posedge clk);
          @(negedge clk);
        end else begin
          @(negedge clk);
        end
      end
      chk($sformatf("arb_accept%0d", g), 32'(ok), 32'd1);
    end
    bus0.d_req_valid  = 1'b0;
    bus0.if_req_valid = 1'b0;
    drain0("arb");

    req3(1'b1, F3_W, 8'h20, 32'hCAFEF00D, "ws3_sw");
    timed3(32'h0, "ws3_sw");
    req3(1'b0, F3_W, 8'h20, 32'h0, "ws3_lw");
    timed3(32'hCAFEF00D, "ws3_lw");

    // Reset pulsed while the store is still in WAIT.
    req3(1'b1, F3_W, 8'h20, 32'h11111111, "abort_sw");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out3", bus3.d_rsp_rdata |
        32'({bus3.d_rsp_valid, bus3.d_rsp_err, bus3.if_rsp_valid,
             bus3.d_req_ready, bus3.if_req_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_after_release", 32'(bus3.d_req_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_rsp_c%0d", k), 32'(bus3.d_rsp_valid | bus3.if_rsp_valid), 32'd0);
    end
    req3(1'b0, F3_W, 8'h20, 32'h0, "abort_lw");
    timed3(32'hCAFEF00D, "abort_lw");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
